// File: rtl/sysctrl_cfgbank_if.sv
// Byte link between the MCU SPI deserialiser and the system-control endpoint.
// Handshake: data_in_strobe is a one-cycle valid with no ready/back-pressure; data_in_start qualifies it as a frame start; data_out is registered on the strobe cycle and shifted out by the MCU during the next byte.
interface sysctrl_cfgbank_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output data_in_strobe, data_in_start, data_in, input data_out);
    modport slave  (input data_in_strobe, data_in_start, data_in, output data_out);
endinterface

// File: rtl/sysctrl_cfgbank.sv
// MCU system-control endpoint: framed byte commands drive a config bank, LEDs, RGB colour
// and an edge/level interrupt controller with mask, readback and burst access.
module sysctrl_cfgbank #(
    parameter logic [7:0]           CORE_ID     = 8'h02,
    parameter int                   NUM_CFG     = 26,
    parameter logic [7:0]           CFG_BASE    = 8'h41,
    parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT = '0,
    parameter int                   NUM_IRQ     = 8,
    parameter logic [7:0]           IRQ_EDGE    = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sysctrl_cfgbank_if.slave     mcu,
    output logic                 int_out_n,
    input  logic [NUM_IRQ-1:0]   int_in,
    output logic [NUM_IRQ-1:0]   int_ack,
    input  logic [1:0]           buttons,
    output logic [1:0]           leds,
    output logic [23:0]          color,
    output logic [NUM_CFG*8-1:0] cfg,
    output logic                 cfg_wr_stb,
    output logic [5:0]           cfg_wr_idx
);
    localparam logic [7:0] CFG_LIM = 8'(NUM_CFG);

    logic [7:0]         cfg_mem [NUM_CFG];
    logic [7:0]         cmd;
    logic [7:0]         ptr;
    logic [3:0]         count;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] int_q;
    logic [NUM_IRQ-1:0] int_q2;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               coldboot;
    logic               exec;
    logic               byte1;
    logic [7:0]         ptr_next;
    logic [7:0]         id_idx;
    logic [7:0]         rd_id;
    logic [7:0]         rd_next;
    logic [7:0]         status;

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_flat
        assign cfg[8*g +: 8] = cfg_mem[g];
    end

    always_comb begin
        exec     = mcu.data_in_strobe && !mcu.data_in_start && (count != 4'd0);
        byte1    = (count == 4'd1);
        ptr_next = ptr + 8'd1;
        id_idx   = mcu.data_in - CFG_BASE;
        // Out-of-range bank reads return zero rather than aliasing.
        rd_id    = (id_idx < CFG_LIM) ? cfg_mem[id_idx[5:0]] : 8'h00;
        rd_next  = (ptr_next < CFG_LIM) ? cfg_mem[ptr_next[5:0]] : 8'h00;
        status    = 8'(pending);
        status[0] = coldboot;
        ack_clr  = (exec && byte1 && cmd == 8'd5) ? mcu.data_in[NUM_IRQ-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_mem[i] <= CFG_DEFAULT[8*i +: 8];
            mcu.data_out <= 8'h00;
            leds         <= 2'b00;
            color        <= 24'h0;
            int_ack      <= '0;
            cfg_wr_stb   <= 1'b0;
            cfg_wr_idx   <= 6'd0;
            mask         <= '1;
            pending      <= '0;
            coldboot     <= 1'b1;
            int_q        <= '0;
            int_q2       <= '0;
            int_out_n    <= 1'b0;
            count        <= 4'd0;
            cmd          <= 8'h00;
            ptr          <= 8'h00;
        end else begin
            cfg_wr_stb <= 1'b0;
            int_ack    <= ack_clr;
            int_q      <= int_in;
            int_q2     <= int_q;
            // A new edge beats a same-cycle ack so no event is lost.
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (IRQ_EDGE[i]) pending[i] <= (int_q[i] & ~int_q2[i]) | (pending[i] & ~ack_clr[i]);
                else             pending[i] <= int_in[i];
            end
            pending[0] <= 1'b0;
            if (ack_clr[0]) coldboot <= 1'b0;
            int_out_n <= ~(coldboot | (|(pending & mask)));

            if (mcu.data_in_strobe && mcu.data_in_start) begin
                cmd   <= mcu.data_in;
                count <= 4'd1;
            end else if (exec) begin
                count        <= (count == 4'd15) ? count : count + 4'd1;
                mcu.data_out <= 8'h00;
                case (cmd)
                    8'd0: begin
                        case (count)
                            4'd1:    mcu.data_out <= 8'h5C;
                            4'd2:    mcu.data_out <= 8'h42;
                            4'd3:    mcu.data_out <= CORE_ID;
                            default: ;
                        endcase
                    end
                    8'd1: if (byte1) leds <= mcu.data_in[1:0];
                    8'd2: begin
                        case (count)
                            4'd1:    color[15:8]  <= bitrev(mcu.data_in);
                            4'd2:    color[7:0]   <= bitrev(mcu.data_in);
                            4'd3:    color[23:16] <= bitrev(mcu.data_in);
                            default: ;
                        endcase
                    end
                    8'd3: mcu.data_out <= {6'b0, buttons};
                    8'd4: begin
                        if (byte1) begin
                            ptr <= id_idx;
                        end else begin
                            if (ptr < CFG_LIM) begin
                                cfg_mem[ptr[5:0]] <= mcu.data_in;
                                cfg_wr_stb        <= 1'b1;
                                cfg_wr_idx        <= ptr[5:0];
                            end
                            ptr <= ptr_next;
                        end
                    end
                    8'd5: mcu.data_out <= status;
                    8'd6: if (byte1) mask <= mcu.data_in[NUM_IRQ-1:0];
                    8'd7: begin
                        if (byte1) begin
                            ptr          <= id_idx;
                            mcu.data_out <= rd_id;
                        end else begin
                            ptr          <= ptr_next;
                            mcu.data_out <= rd_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sysctrl_cfgbank.sv
// Bench for sysctrl_cfgbank: directed scenarios with literal expectations plus randomized
// frames, all outputs compared every cycle against a command-level reference model.
module tb_sysctrl_cfgbank;
    localparam int                NCFG = 26;
    localparam int                NIRQ = 8;
    localparam logic [7:0]        CORE = 8'h02;
    localparam logic [7:0]        BASE = 8'h41;
    localparam logic [7:0]        EDGE = 8'h08;
    localparam logic [NCFG*8-1:0] DEF  = {13{16'hA53C}};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NIRQ-1:0]   int_in = '0;
    logic [1:0]        buttons = 2'b00;
    logic              int_out_n;
    logic [NIRQ-1:0]   int_ack;
    logic [1:0]        leds;
    logic [23:0]       color;
    logic [NCFG*8-1:0] cfg;
    logic              cfg_wr_stb;
    logic [5:0]        cfg_wr_idx;

    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;

    sysctrl_cfgbank_if bus();

    sysctrl_cfgbank #(
        .CORE_ID(CORE), .NUM_CFG(NCFG), .CFG_BASE(BASE),
        .CFG_DEFAULT(DEF), .NUM_IRQ(NIRQ), .IRQ_EDGE(EDGE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mcu(bus),
        .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .cfg(cfg),
        .cfg_wr_stb(cfg_wr_stb), .cfg_wr_idx(cfg_wr_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_cfg [NCFG];
    logic [1:0]  m_leds;
    logic [23:0] m_color;
    logic [7:0]  m_dout, m_mask, m_pend, m_ack;
    logic        m_cold, m_intn, m_stb;
    logic [5:0]  m_idx;
    int          m_cmd, m_pos, m_ptr;
    logic [7:0]  hist[$];

    function automatic logic [7:0] m_rd(input int p);
        return (p < NCFG) ? m_cfg[p] : 8'h00;
    endfunction

    function automatic logic [NCFG*8-1:0] m_flat();
        logic [NCFG*8-1:0] v;
        for (int i = 0; i < NCFG; i++) v[8*i +: 8] = m_cfg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCFG; i++) m_cfg[i] = DEF[8*i +: 8];
        m_leds = 2'b00; m_color = 24'h0; m_dout = 8'h00; m_mask = 8'hFF;
        m_pend = 8'h00; m_ack = 8'h00; m_cold = 1'b1; m_intn = 1'b0;
        m_stb = 1'b0; m_idx = 6'd0; m_cmd = 0; m_pos = 0; m_ptr = 0;
        hist = {};
        hist.push_back(8'h00);
        hist.push_back(8'h00);
    endtask

    task automatic model_step();
        logic [7:0] d, rises, ackv, status, rv, in_now;
        int p;
        d = bus.data_in;
        in_now = int_in;
        rises = hist[1] & ~hist[0];
        ackv = 8'h00;
        status = {m_pend[7:1], m_cold};
        m_intn = !(m_cold || ((m_pend & m_mask) != 8'h00));
        m_stb = 1'b0;
        if (bus.data_in_strobe && bus.data_in_start) begin
            m_cmd = int'(d);
            m_pos = 1;
        end else if (bus.data_in_strobe && m_pos > 0) begin
            p = m_pos;
            m_dout = 8'h00;
            for (int b = 0; b < 8; b++) rv[b] = d[7-b];
            case (m_cmd)
                0: m_dout = (p == 1) ? 8'h5C : (p == 2) ? 8'h42 : (p == 3) ? CORE : 8'h00;
                1: if (p == 1) m_leds = d[1:0];
                2: begin
                    if (p == 1) m_color[15:8] = rv;
                    if (p == 2) m_color[7:0] = rv;
                    if (p == 3) m_color[23:16] = rv;
                end
                3: m_dout = {6'b0, buttons};
                4: begin
                    if (p == 1) m_ptr = (int'(d) - int'(BASE)) & 255;
                    else begin
                        if (m_ptr < NCFG) begin
                            m_cfg[m_ptr] = d;
                            m_stb = 1'b1;
                            m_idx = 6'(m_ptr);
                        end
                        m_ptr = (m_ptr + 1) % 256;
                    end
                end
                5: begin
                    m_dout = status;
                    if (p == 1) ackv = d;
                end
                6: if (p == 1) m_mask = d;
                7: begin
                    if (p == 1) m_ptr = (int'(d) - int'(BASE)) & 255;
                    else m_ptr = (m_ptr + 1) % 256;
                    m_dout = m_rd(m_ptr);
                end
                default: ;
            endcase
            m_pos = p + 1;
        end
        m_ack = ackv;
        for (int i = 1; i < NIRQ; i++)
            m_pend[i] = EDGE[i] ? (rises[i] | (m_pend[i] & ~ackv[i])) : in_now[i];
        m_pend[0] = 1'b0;
        if (ackv[0]) m_cold = 1'b0;
        hist.push_back(in_now);
        void'(hist.pop_front());
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("data_out", 256'(bus.data_out), 256'(m_dout));
            chk("leds", 256'(leds), 256'(m_leds));
            chk("color", 256'(color), 256'(m_color));
            chk("cfg", 256'(cfg), 256'(m_flat()));
            chk("int_out_n", 256'(int_out_n), 256'(m_intn));
            chk("int_ack", 256'(int_ack), 256'(m_ack));
            chk("cfg_wr_stb", 256'(cfg_wr_stb), 256'(m_stb));
            if (m_stb) chk("cfg_wr_idx", 256'(cfg_wr_idx), 256'(m_idx));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic st, input logic [7:0] d);
        @(negedge clk);
        bus.data_in_strobe = 1'b1;
        bus.data_in_start  = st;
        bus.data_in        = d;
        @(negedge clk);
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NCFG*8-1:0] e;
        int k, nb;
        logic [7:0] c, b;
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
        bus.data_in        = 8'h00;
        model_reset();
        idle(3);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // T1: reset image, id bytes, colour, coldboot clear
        chk("t1_cfg_reset", 256'(cfg), 256'(DEF));
        chk("t1_intn_reset", 256'(int_out_n), 256'(1'b0));
        send(1'b1, 8'h00);
        send(1'b0, 8'hAA); chk("t1_id0", 256'(bus.data_out), 256'(8'h5C));
        send(1'b0, 8'hAA); chk("t1_id1", 256'(bus.data_out), 256'(8'h42));
        send(1'b0, 8'hAA); chk("t1_id2", 256'(bus.data_out), 256'(8'h02));
        send(1'b0, 8'hAA); chk("t1_id3", 256'(bus.data_out), 256'(8'h00));
        send(1'b1, 8'h02); send(1'b0, 8'h01); send(1'b0, 8'h80); send(1'b0, 8'h0F);
        chk("t1_color", 256'(color), 256'(24'hF08001));
        send(1'b1, 8'h05);
        send(1'b0, 8'h01);
        chk("t1_status", 256'(bus.data_out), 256'(8'h01));
        chk("t1_ack", 256'(int_ack), 256'(8'h01));
        idle(2);
        chk("t1_intn_clear", 256'(int_out_n), 256'(1'b1));

        // T2: single write in range, then index 26 dropped
        e = DEF;
        e[17*8 +: 8] = 8'h03;
        send(1'b1, 8'h04); send(1'b0, 8'h52); send(1'b0, 8'h03);
        chk("t2_stb", 256'(cfg_wr_stb), 256'(1'b1));
        chk("t2_idx", 256'(cfg_wr_idx), 256'(6'd17));
        idle(1);
        chk("t2_stb_one", 256'(cfg_wr_stb), 256'(1'b0));
        chk("t2_cfg", 256'(cfg), 256'(e));
        send(1'b1, 8'h04); send(1'b0, 8'h5B); send(1'b0, 8'h55);
        chk("t2_oor_stb", 256'(cfg_wr_stb), 256'(1'b0));
        chk("t2_oor_cfg", 256'(cfg), 256'(e));

        // T3: burst write then burst readback
        send(1'b1, 8'h04); send(1'b0, 8'h41);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'(i + 1));
            chk("t3_stb", 256'(cfg_wr_stb), 256'(1'b1));
            chk("t3_idx", 256'(cfg_wr_idx), 256'(i));
            e[8*i +: 8] = 8'(i + 1);
        end
        chk("t3_cfg", 256'(cfg), 256'(e));
        send(1'b1, 8'h07);
        send(1'b0, 8'h41); chk("t3_rb0", 256'(bus.data_out), 256'(8'h01));
        send(1'b0, 8'hEE); chk("t3_rb1", 256'(bus.data_out), 256'(8'h02));
        send(1'b0, 8'hEE); chk("t3_rb2", 256'(bus.data_out), 256'(8'h03));

        // T4: edge source 3, status, ack, and edge coincident with ack
        @(negedge clk); int_in = 8'h08;
        @(negedge clk); int_in = 8'h00;
        idle(4);
        chk("t4_intn_set", 256'(int_out_n), 256'(1'b0));
        send(1'b1, 8'h05); send(1'b0, 8'h08);
        chk("t4_status", 256'(bus.data_out), 256'(8'h08));
        chk("t4_ack", 256'(int_ack), 256'(8'h08));
        idle(2);
        chk("t4_intn_clr", 256'(int_out_n), 256'(1'b1));
        send(1'b1, 8'h05);
        int_in = 8'h08;
        @(negedge clk);
        int_in = 8'h00;
        bus.data_in_strobe = 1'b1; bus.data_in_start = 1'b0; bus.data_in = 8'h08;
        @(negedge clk);
        bus.data_in_strobe = 1'b0;
        chk("t4_coinc_ack", 256'(int_ack), 256'(8'h08));
        idle(3);
        chk("t4_coinc_intn", 256'(int_out_n), 256'(1'b0));
        send(1'b1, 8'h05); send(1'b0, 8'h08);
        chk("t4_coinc_status", 256'(bus.data_out), 256'(8'h08));
        idle(2);

        // T5: mask a level source
        int_in = 8'h04;
        idle(3);
        chk("t5_level", 256'(int_out_n), 256'(1'b0));
        send(1'b1, 8'h06); send(1'b0, 8'h00);
        idle(3);
        chk("t5_masked", 256'(int_out_n), 256'(1'b1));
        send(1'b1, 8'h06); send(1'b0, 8'hFF);
        idle(3);
        chk("t5_unmasked", 256'(int_out_n), 256'(1'b0));
        int_in = 8'h00;
        idle(2);

        // T6: reset in the middle of a burst
        send(1'b1, 8'h04); send(1'b0, 8'h41); send(1'b0, 8'h11);
        do_reset();
        chk("t6_cfg", 256'(cfg), 256'(DEF));
        chk("t6_intn", 256'(int_out_n), 256'(1'b0));
        send(1'b0, 8'h77);
        chk("t6_ignored_stb", 256'(cfg_wr_stb), 256'(1'b0));
        chk("t6_ignored_cfg", 256'(cfg), 256'(DEF));
        chk("t6_ignored_dout", 256'(bus.data_out), 256'(8'h00));

        // Randomized frames
        for (int it = 0; it < 600; it++) begin
            k = $urandom_range(0, 99);
            int_in = 8'($urandom);
            buttons = 2'($urandom);
            if (k < 2) begin
                do_reset();
            end else if (k < 8) begin
                send(1'b0, 8'($urandom));
            end else begin
                c = 8'($urandom_range(0, 11));
                send(1'b1, c);
                nb = $urandom_range(1, 7);
                for (int j = 0; j < nb; j++) begin
                    if (j == 0 && (c == 8'd4 || c == 8'd7)) b = 8'($urandom_range(8'h3C, 8'h5D));
                    else b = 8'($urandom);
                    int_in = 8'($urandom);
                    buttons = 2'($urandom);
                    send(1'b0, b);
                    idle($urandom_range(0, 2));
                end
            end
        end
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
